// File: rtl/frame_pkg.sv
// Shared definitions for the parity-appending frame generator and the
// frame_parity_checker receive stage.
//   state_t             : receive FSM states (IDLE, COLLECT, HOLD)
//   FRAME_BYTES_DEFAULT : default number of bytes per frame
//   even_parity()       : parity bit that makes {parity, byte} even
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int FRAME_BYTES_DEFAULT = 16;

  // Bit to append so that the 9-bit word has an even number of ones.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/parity_check_byte.sv
// Combinational even-parity checker for one 9-bit {parity, data} word.
// Ports:
//   word [8:0] : input, [8] received parity bit, [7:0] data byte
//   bad        : output, 1 when the word does not have even parity
module parity_check_byte
  import frame_pkg::*;
(
  input  logic [8:0] word,
  output logic       bad
);

  assign bad = (word[8] != even_parity(word[7:0]));

endmodule

// File: rtl/frame_parity_checker.sv
// Receive-side frame assembler with per-byte even-parity checking.
// Collects FRAME_BYTES words after a start pulse into a parallel buffer,
// records a per-byte parity-error mask and holds the finished frame for a
// downstream consumer.
//
// Optional feature: define FRAME_PARITY_CHECKER_ERR_CNT_EN to build the
// saturating parity-error counter; otherwise err_count is tied to 0.
//
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   start          : one-cycle frame-start marker
//   in_valid/in_data/in_ready : word input, in_data = {parity, byte}
//   frame_data     : assembled frame, byte i at [8i+7:8i]
//   frame_err_mask : bit i set when byte i failed parity
//   frame_err      : OR of frame_err_mask
//   frame_valid/frame_ready : frame output handshake
//   err_count      : saturating count of bad bytes since reset
//   dbg_state      : current FSM state for observation
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready
// (and no start pulse); a frame transfers on a rising edge where
// frame_valid && frame_ready. frame_valid never depends on frame_ready.
module frame_parity_checker
  import frame_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [8:0]               in_data,
  output logic                     in_ready,
  output logic [FRAME_BYTES*8-1:0] frame_data,
  output logic [FRAME_BYTES-1:0]   frame_err_mask,
  output logic                     frame_err,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [ERR_CNT_W-1:0]     err_count,
  output state_t                   dbg_state
);

  localparam int IDX_W = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] idx;
  logic             byte_bad;
  logic             accept;
  logic             clear;

  parity_check_byte u_parity (
    .word (in_data),
    .bad  (byte_bad)
  );

  // A start pulse outranks a word in the same cycle: the word is dropped.
  assign accept    = (state == COLLECT) && in_valid && !start;
  assign clear     = start && (state != HOLD);
  assign in_ready  = (state == COLLECT);
  assign frame_err = |frame_err_mask;
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = COLLECT;
      COLLECT: if (accept && (idx == LAST_IDX)) state_nx = HOLD;
      HOLD:    if (frame_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx            <= '0;
      frame_data     <= '0;
      frame_err_mask <= '0;
      frame_valid    <= 1'b0;
    end else begin
      // Registered copy of "next state is HOLD" so frame_valid is a flop.
      frame_valid <= (state_nx == HOLD);
      if (clear) begin
        idx            <= '0;
        frame_err_mask <= '0;
      end else if (accept) begin
        for (int i = 0; i < FRAME_BYTES; i++) begin
          if (idx == IDX_W'(i)) begin
            frame_data[8*i +: 8] <= in_data[7:0];
            frame_err_mask[i]    <= byte_bad;
          end
        end
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
    end
  end

`ifdef FRAME_PARITY_CHECKER_ERR_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (accept && byte_bad && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end
`else
  assign err_count = '0;
`endif

endmodule
